fifo_rd_ctrl: RTL and testbench

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

---
 rtl/fifo_rd_pkg.sv | 15 +
 rtl/rd_skid_buf.sv | 56 +++++
 rtl/fifo_rd_ctrl.sv | 102 ++++++++++
 tb/tb_fifo_rd_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types and default constants for the FIFO read controller.
// Used by fifo_rd_ctrl and rd_skid_buf.
package fifo_rd_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_RD_LAT = 2;
    localparam int DEF_SKID   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/rd_skid_buf.sv
// Circular skid buffer that absorbs FIFO read data.
// Push and pop may coincide, even when full or holding one entry.
module rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_SKID,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign data    = mem[rptr];

    // Storage, pointers and occupancy; reset clears entries so data reads 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= next_ptr(wptr);
            end
            if (do_pop) rptr <= next_ptr(rptr);
            if (do_push && !do_pop) count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// FIFO read controller: pops a latency-RD_LAT FIFO into a skid buffer.
// Optional beat counter output enabled by macro FIFO_RD_CTRL_BEATCNT_EN.
module fifo_rd_ctrl
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int RD_LAT = DEF_RD_LAT,
    parameter int SKID   = DEF_SKID
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             fifo_rempty,
    output logic             fifo_rinc,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
`ifdef FIFO_RD_CTRL_BEATCNT_EN
    ,
    output logic [15:0]      beat_cnt
`endif
);

    localparam int CW = $clog2(SKID + 1);

    state_t            state;
    logic [RD_LAT-1:0] pipe;
    logic [CW-1:0]     skid_count;
    logic [CW-1:0]     inflight_count;
    logic [CW:0]       occupancy;
    logic              skid_full;
    logic              skid_empty;
    logic              xfer;

    // Count pops still travelling through the FIFO read latency.
    always_comb begin
        inflight_count = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight_count = inflight_count + CW'(pipe[i]);
        end
    end

    // Pop only while running and the skid has room for every outstanding beat.
    always_comb begin
        occupancy = {1'b0, skid_count} + {1'b0, inflight_count};
        fifo_rinc = (state == RUN) && en && !fifo_rempty && !skid_full
                    && (occupancy < (CW + 1)'(SKID));
    end

    assign out_valid = !skid_empty;
    assign xfer      = out_valid && out_ready;
    assign busy      = (state != IDLE) || !skid_empty;

    // Control FSM: IDLE -> RUN on en, RUN -> DRAIN on !en, DRAIN waits out pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE:    if (en) state <= RUN;
                RUN:     if (!en) state <= DRAIN;
                DRAIN: begin
                    if (en) state <= RUN;
                    else if (inflight_count == '0) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // In-flight shift register; the exiting bit marks valid fifo_rdata.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pipe <= '0;
        else     pipe <= (pipe << 1) | RD_LAT'(fifo_rinc);
    end

    rd_skid_buf #(
        .WIDTH (WIDTH),
        .DEPTH (SKID)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (pipe[RD_LAT-1]),
        .pop   (xfer),
        .wdata (fifo_rdata),
        .data  (out_data),
        .count (skid_count),
        .full  (skid_full),
        .empty (skid_empty)
    );

`ifdef FIFO_RD_CTRL_BEATCNT_EN
    // Transferred beat counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       beat_cnt <= '0;
        else if (xfer) beat_cnt <= beat_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl with a latency FIFO model.
// Beat counter checks compile in with FIFO_RD_CTRL_BEATCNT_EN.
module tb_fifo_rd_ctrl;

    localparam int WIDTH  = 8;
    localparam int RD_LAT = 2;
    localparam int SKID   = 4;

    logic             clk = 0;
    logic             rst;
    logic             en;
    logic             fifo_rempty;
    logic             fifo_rinc;
    logic [WIDTH-1:0] fifo_rdata;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;
`ifdef FIFO_RD_CTRL_BEATCNT_EN
    logic [15:0]      beat_cnt;
`endif

    fifo_rd_ctrl #(
        .WIDTH  (WIDTH),
        .RD_LAT (RD_LAT),
        .SKID   (SKID)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .fifo_rempty (fifo_rempty),
        .fifo_rinc   (fifo_rinc),
        .fifo_rdata  (fifo_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy)
`ifdef FIFO_RD_CTRL_BEATCNT_EN
        ,
        .beat_cnt    (beat_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] fifo_q [$];
    logic [7:0] sb_q [$];
    int         sb_t [$];
    logic [7:0] rd_pipe [RD_LAT];
    int         cyc = 0;
    bit         en_prev = 0;
    bit         toggle_mode = 0;
    bit         rand_empty = 0;
    logic [15:0] exp_cnt = 0;

    int n_pops, n_beats, gaps, pop_run, max_pop_run;
    int first_pop, first_valid, last_beat;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_stats();
        n_pops = 0; n_beats = 0; gaps = 0; pop_run = 0; max_pop_run = 0;
        first_pop = -1; first_valid = -1; last_beat = -1;
    endtask

    task automatic refresh_empty();
        fifo_rempty = (fifo_q.size() == 0)
                      || (toggle_mode && cyc[0])
                      || (rand_empty && ($urandom_range(0, 1) == 1));
    endtask

    task automatic load(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(first + 8'(i));
        refresh_empty();
    endtask

    // One clock: check at negedge against the model, then advance the model.
    task automatic step();
        bit         exp_rinc, exp_valid, do_pop, do_xfer;
        logic [7:0] val;
        int         c;
        @(negedge clk);
        c = cyc;
        exp_rinc = en_prev && en && !fifo_rempty && (sb_q.size() < SKID);
        chk("rinc", 32'(fifo_rinc), 32'(exp_rinc));
        exp_valid = 0;
        if (sb_q.size() > 0) exp_valid = (sb_t[0] + RD_LAT + 1 <= c);
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        if (exp_valid) chk("out_data", 32'(out_data), 32'(sb_q[0]));
        if (sb_q.size() != 0 || en_prev) chk("busy", 32'(busy), 32'd1);
`ifdef FIFO_RD_CTRL_BEATCNT_EN
        chk("beat_cnt", 32'(beat_cnt), 32'(exp_cnt));
`endif
        do_pop  = fifo_rinc;
        do_xfer = exp_valid && out_ready;
        if (do_pop) begin
            n_pops++;
            pop_run++;
            if (pop_run > max_pop_run) max_pop_run = pop_run;
            if (first_pop < 0) first_pop = c;
        end else begin
            pop_run = 0;
        end
        if (out_valid && first_valid < 0) first_valid = c;
        if (do_xfer) begin
            if (last_beat >= 0 && c - last_beat > 1) gaps++;
            last_beat = c;
            n_beats++;
        end
        @(posedge clk);
        #1;
        cyc++;
        en_prev = en;
        val = 8'hEE;
        if (do_pop && fifo_q.size() > 0) val = fifo_q.pop_front();
        for (int i = RD_LAT - 1; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
        rd_pipe[0] = do_pop ? val : 8'hEE;
        if (do_pop) begin
            sb_q.push_back(val);
            sb_t.push_back(c);
        end
        if (do_xfer) begin
            void'(sb_q.pop_front());
            void'(sb_t.pop_front());
            exp_cnt++;
        end
        fifo_rdata = rd_pipe[RD_LAT-1];
        refresh_empty();
    endtask

    task automatic do_reset();
        rst = 1;
        #1;
        chk("rst_rinc", 32'(fifo_rinc), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        en = 0;
        rst = 0;
        sb_q.delete();
        sb_t.delete();
        en_prev = 0;
        exp_cnt = 0;
        for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = 8'hEE;
    endtask

    initial begin
        rst = 1; en = 0; out_ready = 0;
        fifo_rdata = '0; fifo_rempty = 1;
        for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = 8'hEE;
        #1;
        chk("init_rinc", 32'(fifo_rinc), 32'd0);
        chk("init_valid", 32'(out_valid), 32'd0);
        chk("init_data", 32'(out_data), 32'd0);
        chk("init_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 0;

        // Streaming
        clr_stats();
        load(8'h11, 5);
        en = 1; out_ready = 1;
        repeat (16) step();
        chk("st_pops", 32'(n_pops), 32'd5);
        chk("st_run", 32'(max_pop_run), 32'd5);
        chk("st_beats", 32'(n_beats), 32'd5);
        chk("st_gaps", 32'(gaps), 32'd0);
        chk("st_lat", 32'(first_valid - first_pop), 32'(RD_LAT + 1));

        // Backpressure
        clr_stats();
        out_ready = 0;
        load(8'h00, 10);
        repeat (12) step();
        chk("bp_pops", 32'(n_pops), 32'(SKID));
        chk("bp_rinc", 32'(fifo_rinc), 32'd0);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_data", 32'(out_data), 32'h00);
        clr_stats();
        out_ready = 1;
        repeat (20) step();
        chk("bp_beats", 32'(n_beats + SKID - SKID), 32'd10);
        chk("bp_gaps", 32'(gaps), 32'd0);
        chk("bp_fifo", 32'(fifo_q.size()), 32'd0);

        // Drain after two pops
        clr_stats();
        load(8'h20, 4);
        for (int k = 0; k < 20 && n_pops < 2; k++) step();
        chk("dr_pops2", 32'(n_pops), 32'd2);
        en = 0;
        #1;
        chk("dr_rinc", 32'(fifo_rinc), 32'd0);
        repeat (10) step();
        chk("dr_beats", 32'(n_beats), 32'd2);
        chk("dr_busy", 32'(busy), 32'd0);
        fifo_q.delete();
        refresh_empty();

        // Reset mid-stream
        clr_stats();
        en = 1;
        load(8'h40, 8);
        repeat (5) step();
        do_reset();
        fifo_q.delete();
        refresh_empty();
        clr_stats();
        repeat (6) step();
        chk("rs_beats", 32'(n_beats), 32'd0);
        chk("rs_valid", 32'(out_valid), 32'd0);

        // Empty flag toggling
        clr_stats();
        toggle_mode = 1;
        en = 1;
        load(8'h60, 30);
        repeat (40) step();
        chk("tg_some", 32'(n_pops > 0), 32'd1);
        toggle_mode = 0;
        en = 0;
        repeat (10) step();
        fifo_q.delete();
        refresh_empty();

        // Randomized traffic
        rand_empty = 1;
        for (int k = 0; k < 1500; k++) begin
            en = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) fifo_q.push_back(8'($urandom));
            step();
        end
        rand_empty = 0;
        en = 0; out_ready = 1;
        repeat (20) step();
        chk("rnd_drained", 32'(sb_q.size()), 32'd0);
        chk("rnd_busy", 32'(busy), 32'd0);

`ifdef FIFO_RD_CTRL_BEATCNT_EN
        do_reset();
        fifo_q.delete();
        clr_stats();
        en = 1; out_ready = 1;
        for (int k = 0; k < 32'h10002 + 200 && n_beats < 32'h10002; k++) begin
            while (fifo_q.size() + n_beats + sb_q.size() < 32'h10002
                   && fifo_q.size() < 8)
                fifo_q.push_back(8'($urandom));
            refresh_empty();
            step();
        end
        en = 0;
        repeat (10) step();
        chk("bc_beats", 32'(n_beats), 32'h10002);
        chk("bc_cnt", 32'(beat_cnt), 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
